temporizador_mmss: RTL
======================

# temporizador_mmss

Countdown timer for the microwave controller: holds the cook time as four BCD digits (MM:SS), accepts keypad digits while the magnetron is off, and counts down once per second while it is on. It is the stage directly upstream of the magnetron on/off control logic. Its `timer_done` output feeds that logic so the magnetron is switched off when the count reaches 00:00. Its digit outputs drive the display decoder.

## Interface
- `TICK_DIV`, default 100: clock cycles per one-second tick. Must be ≥ 2. Set to the board clock frequency in synthesis; keep it small in simulation.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `clearn`  in  1  keypad CLEAR, active-low, sampled synchronously as a level.
- `mag_on`  in  1  magnetron-on state from the on/off latch; enables the countdown.
- `digit_valid`  in  1  single-cycle strobe from the keypad encoder.
- `digit`  in  4  BCD key value, qualified by `digit_valid`.
- `min_tens`, `min_units`, `sec_tens`, `sec_units`  out  4 each  BCD count.
- `timer_done`  out  1  high when all four digits are zero.

## Operation
- Reset: all digits are 0, the prescaler is 0, and `timer_done` is 1.
- Update priority, highest first:
  - `rst`
  - `clearn`=0: all digits and the prescaler go to 0.
  - countdown
  - digit entry
- Digit entry:
  - Acts only when `digit_valid`=1, `mag_on`=0, `clearn`=1, and `digit` ≤ 9. Otherwise the strobe is ignored.
  - The digits shift left: `min_tens`←`min_units`←`sec_tens`←`sec_units`←`digit`. The old `min_tens` is discarded.
- Prescaler:
  - Counts 0..TICK_DIV-1 only while `mag_on`=1 and `timer_done`=0.
  - Holds its value while `mag_on`=0, so pause/resume preserves the partial second.
  - Clears to 0 on `clearn`=0 and when the count reaches zero.
- Countdown: on a cycle where the prescaler equals TICK_DIV-1, `mag_on`=1 and `timer_done`=0:
  - The prescaler wraps to 0.
  - MM:SS decrements by one second.
- Decrement rules:
  - `sec_units`: 0→9 with borrow, else −1.
  - `sec_tens`: on borrow, 0→5 with borrow, else −1.
  - `min_units`: 0→9 with borrow.
  - `min_tens`: −1.
- Entered seconds ≥ 60 (e.g. 00:75) are legal. They decrement naturally: 75→74…→60→59. No normalisation is done.
- The count never goes below 00:00. At zero the decrement is suppressed.
- `timer_done` = (all digits == 0). It is decoded from registers, so it has no added latency.
- Maximum entry is 99:99; the maximum meaningful time is 99:59.

## Timing
- A digit entry is visible on the outputs the cycle after the `digit_valid` edge.
- From `mag_on` rising with the prescaler at 0, the first decrement appears TICK_DIV cycles later. Subsequent decrements follow every TICK_DIV cycles.
- `timer_done` rises in the same cycle the digits become 00:00. The downstream control asserts its magnetron reset from that level.
- If `mag_on` falls in the tick cycle itself, the decrement does not occur (it is sampled on the same edge).
- `clearn`=0 while `mag_on`=1 zeroes the count immediately, which raises `timer_done`.
- Synchronous `rst` mid-count returns every output to its reset value on the next edge, regardless of the other inputs.
- `digit_valid` with `mag_on`=1 never alters the count, even on a non-tick cycle.

## Structure
- A shared package, `microondas_pkg`, holds:
  - the BCD digit typedef (4-bit)
  - the constants `BCD_MAX`=9 and `SEC_TENS_MAX`=5
- One sub-module, `bcd_down_digit`:
  - Inputs: `clk`, `rst`, `clr`, `load_en`, `load_val`, `dec_en`, `wrap_val`.
  - Outputs: `q`, `borrow_out`.
  - Instantiated four times: `wrap_val`=9, 5, 9, 9. The borrow chain feeds `dec_en` of the next-higher digit.
  - The shift-entry path uses `load_en`/`load_val`.
- The prescaler and the zero detect live in the top.

## Test plan
All scenarios use TICK_DIV=4.
- Reset then idle → all digits 0, `timer_done`=1. Ticks with `mag_on`=0 leave the count unchanged.
- Entry: digits 1,3,0 strobed with `mag_on`=0 → 01:30 and `timer_done`=0. A fifth and sixth digit shift out the leading ones, e.g. 1,2,3,4,5 → 23:45. A strobe with `digit`=12 is ignored.
- Countdown with borrow: load 01:00, raise `mag_on` → 00:59 after 4 cycles, then 00:58 four cycles later.
- Count to zero: load 00:02 with `mag_on`=1 → 00:01 at cycle 4, 00:00 and `timer_done`=1 at cycle 8. The count stays at 00:00 thereafter.
- Pause/resume: load 00:10, `mag_on`=1 for 6 cycles, then 0 for 10 cycles, then 1 → first decrement to 00:09 at cycle 4. The next decrement, to 00:08, comes 2 cycles after resume.
- Priority: `clearn`=0 during countdown at 00:45 → 00:00 next edge. `rst` asserted together with `digit_valid` → reset values. Entry of 00:75 decrements 75→74.

Source files
------------

// File: rtl/microondas_pkg.sv
// Shared types and constants for the microwave controller.
// BCD digit type plus the wrap values used by the MM:SS countdown.
package microondas_pkg;
   typedef logic [3:0] bcd_t;
   localparam bcd_t BCD_MAX      = 4'd9;
   localparam bcd_t SEC_TENS_MAX = 4'd5;
endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the countdown: clear, decrement-with-wrap, or shift-load.
// borrow_out is combinational so a whole MM:SS borrow ripples in one cycle.
module bcd_down_digit
   import microondas_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic load_en,
   input  bcd_t load_val,
   input  logic dec_en,
   input  bcd_t wrap_val,
   output bcd_t q,
   output logic borrow_out
);

   assign borrow_out = dec_en && (q == 4'd0);

   always_ff @(posedge clk) begin
      if (rst)
         q <= '0;
      else if (clr)
         q <= '0;
      else if (dec_en)
         q <= (q == 4'd0) ? wrap_val : q - 4'd1;
      else if (load_en)
         q <= load_val;
   end

endmodule

// File: rtl/temporizador_mmss.sv
// MM:SS countdown timer: keypad shift-entry while idle, 1 Hz countdown while
// the magnetron is on, and a zero flag for the on/off control.
module temporizador_mmss
   import microondas_pkg::*;
#(
   parameter int TICK_DIV = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clearn,
   input  logic       mag_on,
   input  logic       digit_valid,
   input  logic [3:0] digit,
   output logic [3:0] min_tens,
   output logic [3:0] min_units,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_units,
   output logic       timer_done
);

   localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] presc;
   bcd_t          q_arr [4];   // [0]=sec_units .. [3]=min_tens
   logic [4:0]    dec;
   logic          zero, run, tick, load_en;

   assign zero       = (q_arr[0] == 4'd0) && (q_arr[1] == 4'd0) &&
                       (q_arr[2] == 4'd0) && (q_arr[3] == 4'd0);
   assign timer_done = zero;
   assign run        = clearn && mag_on && !zero;
   assign tick       = run && (presc == P_LAST);
   assign load_en    = digit_valid && !mag_on && clearn && (digit <= BCD_MAX);
   assign dec[0]     = tick;

   // Holding on mag_on=0 keeps the partial second across pause/resume.
   always_ff @(posedge clk) begin
      if (rst)
         presc <= '0;
      else if (!clearn)
         presc <= '0;
      else if (run)
         presc <= tick ? '0 : presc + 1'b1;
      else if (zero)
         presc <= '0;
   end

   // Borrow out of min_tens cannot occur: the tick is gated off at 00:00.
   for (genvar i = 0; i < 4; i++) begin : g_dig
      bcd_down_digit u_dig (
         .clk        (clk),
         .rst        (rst),
         .clr        (!clearn),
         .load_en    (load_en),
         .load_val   ((i == 0) ? bcd_t'(digit) : q_arr[(i == 0) ? 0 : i-1]),
         .dec_en     (dec[i]),
         .wrap_val   ((i == 1) ? SEC_TENS_MAX : BCD_MAX),
         .q          (q_arr[i]),
         .borrow_out (dec[i+1])
      );
   end

   assign sec_units = q_arr[0];
   assign sec_tens  = q_arr[1];
   assign min_units = q_arr[2];
   assign min_tens  = q_arr[3];

endmodule
